// File: rtl/alu_exec_seq.sv
// Sequential ALU execute unit: single-cycle logic/arithmetic ops, serial 1-bit-per-cycle shifter,
// valid/ready on both sides with a registered result, zero and illegal flags.
module alu_exec_seq #(
    parameter int unsigned W   = 32,
    parameter int unsigned SHW = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [3:0]     ALUCtrl,
    input  logic [W-1:0]   src_a,
    input  logic [W-1:0]   src_b,
    input  logic [SHW-1:0] shamt,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   result,
    output logic           zero,
    output logic           illegal
);

    localparam logic [3:0] CtrlAnd = 4'b0000;
    localparam logic [3:0] CtrlOr  = 4'b0001;
    localparam logic [3:0] CtrlAdd = 4'b0010;
    localparam logic [3:0] CtrlSub = 4'b0110;
    localparam logic [3:0] CtrlSlt = 4'b0111;
    localparam logic [3:0] CtrlSll = 4'b0100;
    localparam logic [3:0] CtrlSrl = 4'b0101;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [SHW-1:0] cnt_q, cnt_d;
    logic           dir_q, dir_d;
    logic [W-1:0]   result_q, result_d;
    logic           zero_q, zero_d;
    logic           illegal_q, illegal_d;

    logic [W-1:0]   alu_res;
    logic           alu_ill;
    logic           is_shift;
    logic [W-1:0]   acc_step;
    logic [W-1:0]   load_val;

    // Single-cycle operation decode; illegal codes leave alu_res at zero.
    always_comb begin
        alu_res  = '0;
        alu_ill  = 1'b0;
        is_shift = 1'b0;
        case (ALUCtrl)
            CtrlAnd: alu_res = src_a & src_b;
            CtrlOr:  alu_res = src_a | src_b;
            CtrlAdd: alu_res = src_a + src_b;
            CtrlSub: alu_res = src_a - src_b;
            CtrlSlt: alu_res = {{(W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            CtrlSll: is_shift = 1'b1;
            CtrlSrl: is_shift = 1'b1;
            default: alu_ill = 1'b1;
        endcase
    end

    // dir_q: 1 shifts right (SRL), 0 shifts left (SLL)
    assign acc_step = dir_q ? (acc_q >> 1) : (acc_q << 1);
    assign load_val = is_shift ? src_b : alu_res;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (is_shift && (shamt != '0)) begin
                        acc_d   = src_b;
                        cnt_d   = shamt;
                        dir_d   = ALUCtrl[0];
                        state_d = StShift;
                    end else begin
                        result_d  = load_val;
                        zero_d    = (load_val == '0);
                        illegal_d = alu_ill;
                        state_d   = StDone;
                    end
                end
            end
            StShift: begin
                acc_d = acc_step;
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    result_d  = acc_step;
                    zero_d    = (acc_step == '0);
                    illegal_d = 1'b0;
                    state_d   = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule
